// File: rtl/mul_issue_ctrl_pkg.sv
// Shared constants for the EX-stage multiplier issue controller:
// op-codes, FSM state encoding and multiplier handshake levels.
package mul_issue_ctrl_pkg;

    localparam logic [2:0] MulOpNop   = 3'b000;
    localparam logic [2:0] MulOpMult  = 3'b001;
    localparam logic [2:0] MulOpMultu = 3'b010;
    localparam logic [2:0] MulOpMthi  = 3'b011;
    localparam logic [2:0] MulOpMtlo  = 3'b100;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusy  = 2'd1;
    localparam logic [1:0] StAbort = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    localparam logic MulStart          = 1'b1;
    localparam logic MulStop           = 1'b0;
    localparam logic MulResultReady    = 1'b1;
    localparam logic MulResultNotReady = 1'b0;

endpackage

// File: rtl/mul_issue_ctrl_hilo_reg.sv
// HI/LO register pair. A whole-pair write (product capture) takes
// priority over the individual MTHI/MTLO writes; in practice they never
// coincide because the mult occupies EX until its capture cycle.
module hilo_reg #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we_hi,
    input  logic                  i_we_lo,
    input  logic                  i_we_pair,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [2*DATA_W-1:0]   i_pair_d,
    output logic [DATA_W-1:0]     o_hi,
    output logic [DATA_W-1:0]     o_lo
);

    // Register pair update: pair capture, else independent half writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_hi <= '0;
            o_lo <= '0;
        end else if (i_we_pair) begin
            o_hi <= i_pair_d[2*DATA_W-1:DATA_W];
            o_lo <= i_pair_d[DATA_W-1:0];
        end else begin
            if (i_we_hi) o_hi <= i_wdata;
            if (i_we_lo) o_lo <= i_wdata;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage initiator for the multi-cycle multiplier. Issues MULT/MULTU,
// holds the multiplier inputs until ready, stalls the pipeline while a
// product is pending, and captures the product into HI/LO.
//
// state | meaning
// IDLE  | multiplier free, a mult in EX may issue
// BUSY  | product pending for the mult still in EX
// ABORT | the mult was flushed; wait for ready and throw the result away
// DRAIN | start dropped; wait for the multiplier to lower ready
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [2:0]            op_code,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic                  flush,
    output logic                  stall_req,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  mul_start_o,
    output logic                  mul_signed_o,
    output logic [DATA_W-1:0]     mul_op1_o,
    output logic [DATA_W-1:0]     mul_op2_o,
    input  logic                  mul_ready_i,
    input  logic [2*DATA_W-1:0]   mul_result_i
);

    logic [1:0] r_state;
    logic       w_is_mult;
    logic       w_is_signed;
    logic       w_is_mthi;
    logic       w_is_mtlo;
    logic       w_ready;
    logic       w_issue;
    logic       w_we_pair;

    // Op-code decode; unknown codes fall through as NOP.
    always_comb begin
        w_is_mult   = 1'b0;
        w_is_signed = 1'b0;
        w_is_mthi   = 1'b0;
        w_is_mtlo   = 1'b0;
        if (op_valid) begin
            case (op_code)
                MulOpNop:   ;
                MulOpMult:  begin w_is_mult = 1'b1; w_is_signed = 1'b1; end
                MulOpMultu: w_is_mult = 1'b1;
                MulOpMthi:  w_is_mthi = 1'b1;
                MulOpMtlo:  w_is_mtlo = 1'b1;
                default:    ;
            endcase
        end
    end

    assign w_ready   = (mul_ready_i == MulResultReady);
    assign w_issue   = (r_state == StIdle) && w_is_mult && !flush;
    assign w_we_pair = (r_state == StBusy) && w_ready && !flush;

    // The mult retires in its capture cycle, so the stall releases there.
    assign stall_req = w_is_mult && !flush && !((r_state == StBusy) && w_ready);

    // Issue FSM; operands and signedness are only loaded on issue so they
    // stay put until ready (the multiplier re-reads the MSBs at the end).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            mul_start_o  <= MulStop;
            mul_signed_o <= 1'b0;
            mul_op1_o    <= '0;
            mul_op2_o    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_issue) begin
                        mul_op1_o    <= rs_data;
                        mul_op2_o    <= rt_data;
                        mul_signed_o <= w_is_signed;
                        mul_start_o  <= MulStart;
                        r_state      <= StBusy;
                    end
                end
                StBusy: begin
                    // A flush coinciding with ready skips ABORT entirely.
                    if (flush && !w_ready) begin
                        r_state <= StAbort;
                    end else if (w_ready) begin
                        mul_start_o <= MulStop;
                        r_state     <= StDrain;
                    end
                end
                StAbort: begin
                    if (w_ready) begin
                        mul_start_o <= MulStop;
                        r_state     <= StDrain;
                    end
                end
                StDrain: begin
                    if (mul_ready_i == MulResultNotReady) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    hilo_reg #(.DATA_W(DATA_W)) u_hilo (
        .clk       (clk),
        .rst       (rst),
        .i_we_hi   (w_is_mthi && !flush),
        .i_we_lo   (w_is_mtlo && !flush),
        .i_we_pair (w_we_pair),
        .i_wdata   (rs_data),
        .i_pair_d  (mul_result_i),
        .o_hi      (hi_o),
        .o_lo      (lo_o)
    );

endmodule
